// File: rtl/shreg_pkg.sv
// Shared constants and FSM state type for the shift_register_n block.
// Latency: n/a (package). Backpressure: n/a.
// Optional parity output of the top is controlled by SHREG_PARITY_EN.
package shreg_pkg;

    localparam logic [1:0] SERIAL_SHIFT = 2'b00;
    localparam logic [1:0] CIRC_SHIFT   = 2'b01;
    localparam logic [1:0] PARA_LOAD    = 2'b10;
    localparam logic [1:0] HOLD         = 2'b11;

    localparam logic LOW    = 1'b0;
    localparam logic ENABLE = 1'b1;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/shift_register_n_if.sv
// Control/data bundle between a stimulus master and the shift_register_n slave.
// Latency: n/a (wires only). Backpressure: none; ENB is the only stall input.
// PARITY exists only when SHREG_PARITY_EN is defined.
interface shift_register_n_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             ENB;
    logic             DIR;
    logic             S_IN;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] D;
    logic [AMT_W-1:0] AMT;
    logic             START;
    logic [WIDTH-1:0] Q;
    logic             S_OUT;
    logic             BUSY;
    logic             DONE;
`ifdef SHREG_PARITY_EN
    logic             PARITY;

    modport master (
        output ENB, DIR, S_IN, MODO, D, AMT, START,
        input  Q, S_OUT, BUSY, DONE, PARITY
    );
    modport slave (
        input  ENB, DIR, S_IN, MODO, D, AMT, START,
        output Q, S_OUT, BUSY, DONE, PARITY
    );
`else
    modport master (
        output ENB, DIR, S_IN, MODO, D, AMT, START,
        input  Q, S_OUT, BUSY, DONE
    );
    modport slave (
        input  ENB, DIR, S_IN, MODO, D, AMT, START,
        output Q, S_OUT, BUSY, DONE
    );
`endif
endinterface

// File: rtl/shreg_ctrl.sv
// Burst controller: FSM, remaining-step count, latched mode/dir, BUSY/DONE.
// Latency: step strobe is combinational for the current edge; BUSY/DONE registered.
// Backpressure: enb low freezes all state and masks DONE until enb returns.
module shreg_ctrl
    import shreg_pkg::*;
#(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             start,
    input  logic [1:0]       modo,
    input  logic             dir,
    input  logic [AMT_W-1:0] amt,
    output logic             step_vld,
    output logic [1:0]       eff_mode,
    output logic             eff_dir,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        done_d   = done_q;
        step_vld = LOW;
        eff_mode = modo;
        eff_dir  = dir;

        if (enb == ENABLE) begin
            done_d = LOW;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_d = modo;
                        dir_d  = dir;
                        if (amt == '0) begin
                            done_d = ENABLE;
                        end else if (modo == PARA_LOAD || modo == HOLD
                                     || amt == AMT_W'(1)) begin
                            // Load/hold bursts collapse to a single step.
                            step_vld = ENABLE;
                            done_d   = ENABLE;
                        end else begin
                            step_vld = ENABLE;
                            cnt_d    = amt - AMT_W'(1);
                            state_d  = BURST;
                        end
                    end else begin
                        step_vld = ENABLE;
                    end
                end
                BURST: begin
                    step_vld = ENABLE;
                    eff_mode = mode_q;
                    eff_dir  = dir_q;
                    cnt_d    = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = ENABLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= HOLD;
            dir_q   <= DIR_LEFT;
            done_q  <= LOW;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == BURST);
    // A completion captured while stalled is held and shown once enb returns.
    assign done = done_q & enb;

endmodule

// File: rtl/shift_register_n.sv
// WIDTH-bit universal shift register with counted burst shift/rotate (SHREG_PARITY_EN adds PARITY).
// Latency: one edge per step; Q/S_OUT registered, PARITY combinational from Q.
// Backpressure: ENB low freezes Q, S_OUT, burst progress and masks DONE.
module shift_register_n
    import shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    shift_register_n_if.slave bus
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             s_out_q, s_out_d;
    logic             step_vld;
    logic [1:0]       eff_mode;
    logic             eff_dir;
    logic             busy;
    logic             done;

    shreg_ctrl #(.AMT_W(AMT_W)) u_ctrl (
        .clk      (CLK),
        .rst      (RESET),
        .enb      (bus.ENB),
        .start    (bus.START),
        .modo     (bus.MODO),
        .dir      (bus.DIR),
        .amt      (bus.AMT),
        .step_vld (step_vld),
        .eff_mode (eff_mode),
        .eff_dir  (eff_dir),
        .busy     (busy),
        .done     (done)
    );

    always_comb begin
        q_d     = q_q;
        s_out_d = s_out_q;
        if (step_vld) begin
            case (eff_mode)
                SERIAL_SHIFT: begin
                    if (eff_dir == DIR_LEFT) begin
                        q_d     = {q_q[WIDTH-2:0], bus.S_IN};
                        s_out_d = q_q[WIDTH-1];
                    end else begin
                        q_d     = {bus.S_IN, q_q[WIDTH-1:1]};
                        s_out_d = q_q[0];
                    end
                end
                CIRC_SHIFT: begin
                    if (eff_dir == DIR_LEFT) begin
                        q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        s_out_d = q_q[WIDTH-1];
                    end else begin
                        q_d     = {q_q[0], q_q[WIDTH-1:1]};
                        s_out_d = q_q[0];
                    end
                end
                PARA_LOAD: begin
                    q_d     = bus.D;
                    s_out_d = LOW;
                end
                default: begin
                    q_d     = q_q;
                    s_out_d = s_out_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            q_q     <= '0;
            s_out_q <= LOW;
        end else begin
            q_q     <= q_d;
            s_out_q <= s_out_d;
        end
    end

    assign bus.Q     = q_q;
    assign bus.S_OUT = s_out_q;
    assign bus.BUSY  = busy;
    assign bus.DONE  = done;
`ifdef SHREG_PARITY_EN
    assign bus.PARITY = ^q_q;
`endif

endmodule

// File: tb/tb_shift_register_n.sv
// Bench for shift_register_n: directed literal checks plus randomized traffic
// compared every cycle against a queue-free step-count reference model.
module tb_shift_register_n;
    import shreg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_register_n_if #(.WIDTH(8), .AMT_W(4)) bus ();
    shift_register_n_if #(.WIDTH(4), .AMT_W(4)) bus4 ();

    shift_register_n #(.WIDTH(8), .AMT_W(4)) dut  (.CLK(clk), .RESET(rst), .bus(bus));
    shift_register_n #(.WIDTH(4), .AMT_W(4)) dut4 (.CLK(clk), .RESET(rst), .bus(bus4));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: register value, last-out bit, steps still owed, pending completion.
    logic [7:0] m_q    = 8'h00;
    logic       m_so   = 1'b0;
    int         m_left = 0;
    logic [1:0] m_mode = HOLD;
    logic       m_dir  = 1'b0;
    logic       m_pend = 1'b0;

    function automatic logic [8:0] step_fn(input logic [1:0] md, input logic dr, input logic si,
                                           input logic [7:0] q, input logic so, input logic [7:0] d);
        logic       out_bit;
        logic       fill;
        logic [7:0] nq;
        out_bit = dr ? q[0] : q[7];
        fill    = (md == CIRC_SHIFT) ? out_bit : si;
        nq      = dr ? ((q >> 1) | (fill ? 8'h80 : 8'h00)) : ((q << 1) | (fill ? 8'h01 : 8'h00));
        case (md)
            SERIAL_SHIFT, CIRC_SHIFT: return {out_bit, nq};
            PARA_LOAD:                return {1'b0, d};
            default:                  return {so, q};
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic       nd;
        int         amt_eff;
        logic [8:0] r;
        if (rst) begin
            m_q = 8'h00; m_so = 1'b0; m_left = 0; m_pend = 1'b0;
        end else if (bus.ENB) begin
            nd = 1'b0;
            if (m_left > 0) begin
                r = step_fn(m_mode, m_dir, bus.S_IN, m_q, m_so, bus.D);
                {m_so, m_q} = r;
                m_left--;
                nd = (m_left == 0);
            end else if (bus.START) begin
                amt_eff = int'(bus.AMT);
                if (amt_eff != 0 && (bus.MODO == PARA_LOAD || bus.MODO == HOLD)) amt_eff = 1;
                if (amt_eff == 0) begin
                    nd = 1'b1;
                end else begin
                    r = step_fn(bus.MODO, bus.DIR, bus.S_IN, m_q, m_so, bus.D);
                    {m_so, m_q} = r;
                    m_left = amt_eff - 1;
                    m_mode = bus.MODO;
                    m_dir  = bus.DIR;
                    nd = (m_left == 0);
                end
            end else begin
                r = step_fn(bus.MODO, bus.DIR, bus.S_IN, m_q, m_so, bus.D);
                {m_so, m_q} = r;
            end
            m_pend = nd;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q", bus.Q, m_q);
            chk("s_out", bus.S_OUT, m_so);
            chk("busy", bus.BUSY, m_left > 0);
            chk("done", bus.DONE, m_pend && bus.ENB);
`ifdef SHREG_PARITY_EN
            chk("parity", bus.PARITY, ^m_q);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [1:0] md, input logic dr, input logic [3:0] amt, input logic [7:0] d);
        bus.MODO = md; bus.DIR = dr; bus.AMT = amt; bus.D = d; bus.START = 1'b1;
        cyc();
        bus.START = 1'b0; bus.MODO = HOLD;
    endtask

    int         done_cnt;
    int         done_at;
    logic [3:0] exp_q4  [4];
    logic       exp_so4 [4];

    initial begin
        bus.ENB = 1'b1; bus.DIR = 1'b0; bus.S_IN = 1'b0; bus.MODO = HOLD;
        bus.D = 8'h00; bus.AMT = 4'd0; bus.START = 1'b0;
        bus4.ENB = 1'b1; bus4.DIR = 1'b0; bus4.S_IN = 1'b0; bus4.MODO = HOLD;
        bus4.D = 4'h0; bus4.AMT = 4'd0; bus4.START = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", bus.Q, 8'h00);
        chk("rst_s_out", bus.S_OUT, 1'b0);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_done", bus.DONE, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Load 0x81, then rotate left by 3.
        go(PARA_LOAD, 1'b0, 4'd5, 8'h81);
        chk("load_q", bus.Q, 8'h81);
        chk("load_done", bus.DONE, 1'b1);
        go(CIRC_SHIFT, 1'b0, 4'd3, 8'h00);
        chk("rot_q1", bus.Q, 8'h03);
        chk("rot_busy1", bus.BUSY, 1'b1);
        cyc();
        chk("rot_q2", bus.Q, 8'h06);
        chk("rot_done2", bus.DONE, 1'b0);
        cyc();
        chk("rot_q3", bus.Q, 8'h0C);
        chk("rot_busy3", bus.BUSY, 1'b0);
        chk("rot_done3", bus.DONE, 1'b1);
        chk("rot_s_out", bus.S_OUT, 1'b0);
        cyc();
        chk("rot_done_pulse", bus.DONE, 1'b0);

        // Serial right fill with ones.
        go(PARA_LOAD, 1'b0, 4'd1, 8'h00);
        bus.S_IN = 1'b1;
        go(SERIAL_SHIFT, 1'b1, 4'd4, 8'h00);
        repeat (3) cyc();
        chk("ser_q", bus.Q, 8'hF0);
        chk("ser_s_out", bus.S_OUT, 1'b0);
        chk("ser_done", bus.DONE, 1'b1);
        bus.S_IN = 1'b0;

        // Two stalled edges inside a 5-step rotate.
        go(PARA_LOAD, 1'b0, 4'd1, 8'hA5);
        bus.MODO = CIRC_SHIFT; bus.DIR = 1'b1; bus.AMT = 4'd5; bus.START = 1'b1;
        cyc();
        bus.START = 1'b0; bus.MODO = HOLD;
        done_cnt = 0; done_at = 0;
        for (int n = 2; n <= 12; n++) begin
            bus.ENB = (n == 3 || n == 4) ? 1'b0 : 1'b1;
            cyc();
            if (bus.DONE) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
        end
        bus.ENB = 1'b1;
        chk("stall_done_edge", done_at, 7);
        chk("stall_done_count", done_cnt, 1);

        // Zero-length burst.
        go(PARA_LOAD, 1'b0, 4'd1, 8'h3C);
        go(CIRC_SHIFT, 1'b0, 4'd0, 8'h00);
        chk("amt0_q", bus.Q, 8'h3C);
        chk("amt0_done", bus.DONE, 1'b1);
        chk("amt0_busy", bus.BUSY, 1'b0);

        // START while busy is ignored.
        go(CIRC_SHIFT, 1'b0, 4'd3, 8'h00);
        bus.MODO = PARA_LOAD; bus.D = 8'hFF; bus.AMT = 4'd1; bus.START = 1'b1;
        cyc();
        bus.START = 1'b0; bus.MODO = HOLD;
        cyc();
        chk("busy_start_q", bus.Q, 8'hE1);
        chk("busy_start_done", bus.DONE, 1'b1);

        go(PARA_LOAD, 1'b0, 4'd1, 8'h07);
        chk("par_q", bus.Q, 8'h07);
`ifdef SHREG_PARITY_EN
        chk("parity_07", bus.PARITY, 1'b1);
`endif

        // Asynchronous reset in the middle of a burst.
        go(PARA_LOAD, 1'b0, 4'd1, 8'h5A);
        go(CIRC_SHIFT, 1'b1, 4'd6, 8'h00);
        chk("mid_busy", bus.BUSY, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_q", bus.Q, 8'h00);
        chk("mid_rst_s_out", bus.S_OUT, 1'b0);
        chk("mid_rst_busy", bus.BUSY, 1'b0);
        chk("mid_rst_done", bus.DONE, 1'b0);
        #2 rst = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            cyc();
            if (bus.DONE) done_cnt++;
        end
        chk("mid_rst_no_done", done_cnt, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bus.ENB   = ($urandom % 8) != 0;
            bus.START = ($urandom % 5) == 0;
            bus.MODO  = 2'($urandom);
            bus.DIR   = 1'($urandom);
            bus.S_IN  = 1'($urandom);
            bus.D     = 8'($urandom);
            bus.AMT   = 4'($urandom);
            if (($urandom % 400) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
            cyc();
        end
        bus.ENB = 1'b1; bus.START = 1'b0; bus.MODO = HOLD;
        cyc();

        // WIDTH=4 free-running rotate.
        exp_q4  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_so4 = '{1'b1, 1'b0, 1'b0, 1'b0};
        bus4.MODO = PARA_LOAD; bus4.D = 4'b1000;
        cyc();
        chk("w4_load", bus4.Q, 4'b1000);
        bus4.MODO = CIRC_SHIFT; bus4.DIR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("w4_q", bus4.Q, exp_q4[i]);
            chk("w4_s_out", bus4.S_OUT, exp_so4[i]);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
